// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-Lite register slave.
//   - AXI response codes used on bresp/rresp
//   - state encodings for the independent write and read FSMs
//   - byte-lane merge helper used when committing a strobed write
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_COMMIT,
      W_RESP
   } w_state_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } r_state_t;

   // Replace only the byte lanes whose strobe bit is set.
   function automatic logic [31:0] merge_bytes(
      input logic [31:0] old_val,
      input logic [31:0] new_val,
      input logic [3:0]  strb
   );
      logic [31:0] result;
      result = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) begin
            result[8*b +: 8] = new_val[8*b +: 8];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/axi_lite_regs_slave_if.sv
// AXI-Lite bus bundle between an interconnect master and the register slave.
//   AW channel : awaddr, awvalid, awready
//   W channel  : wdata, wstrb, wvalid, wready
//   B channel  : bresp, bvalid, bready
//   AR channel : araddr, arvalid, arready
//   R channel  : rdata, rresp, rvalid, rready
// Modports: master drives addresses/data/readies for responses,
//           slave drives the address/data readies and the responses.
interface axi_lite_regs_slave_if;

   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/axi_lite_addr_decode.sv
// Combinational address decoder for the register slave.
//   addr      in  : byte address from an AW or AR channel
//   idx       out : word index relative to BASE_ADDR (low bits only)
//   is_reg    out : address hits one of the N_REGS read/write registers
//   is_status out : address hits the read-only status word at offset N_REGS*4
// Anything else is out of range. Address bits [1:0] are ignored.
module axi_lite_addr_decode
   import axi_lite_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          N_REGS    = 8,
   parameter int          IDX_W     = 3
) (
   input  logic [31:0]      addr,
   output logic [IDX_W-1:0] idx,
   output logic             is_reg,
   output logic             is_status
);

   logic [31:0] off;
   logic [29:0] word;
   logic        unused_low;

   assign off        = addr - BASE_ADDR;
   assign word       = off[31:2];
   assign unused_low = ^off[1:0];

   // The full word index is compared, so addresses wrapping below BASE_ADDR
   // become huge indices and fall out of range.
   assign idx       = word[IDX_W-1:0];
   assign is_reg    = (word < 30'(N_REGS));
   assign is_status = (word == 30'(N_REGS));

endmodule

// File: rtl/axi_lite_regs_slave.sv
// AXI-Lite responder exposing N_REGS read/write 32-bit registers plus one
// read-only status word, one outstanding write and one outstanding read.
//   clk, rst   : single clock, synchronous active-high reset
//   bus        : AXI-Lite slave modport (AW/W/B/AR/R channels)
//   status_in  : sampled into rdata when the status word is read
//   reg_out    : flattened register contents, reg k at [32k+31:32k]
//   wr_pulse   : one-cycle strobe per register, raised after it is written
// Write path: AW and W are captured independently, one commit cycle applies
// the strobed write, then B is held until bready. Read path: AR capture
// registers rdata/rresp, which stay stable until rready.
module axi_lite_regs_slave
   import axi_lite_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          N_REGS    = 8,
   parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   axi_lite_regs_slave_if.slave bus,
   input  logic [31:0]          status_in,
   output logic [N_REGS*32-1:0] reg_out,
   output logic [N_REGS-1:0]    wr_pulse
);

   localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;

   // ------------------------------------------------------------------
   // Register file
   // ------------------------------------------------------------------
   logic [31:0] regs_reg [N_REGS];

   // ------------------------------------------------------------------
   // Write channel state
   // ------------------------------------------------------------------
   w_state_t    w_state_reg;
   logic        aw_held_reg;
   logic        w_held_reg;
   logic [31:0] awaddr_reg;
   logic [31:0] wdata_reg;
   logic [3:0]  wstrb_reg;
   logic        awready_reg;
   logic        wready_reg;
   logic        bvalid_reg;
   logic [1:0]  bresp_reg;
   logic [N_REGS-1:0] wr_pulse_reg;

   logic             aw_fire;
   logic             w_fire;
   logic [IDX_W-1:0] w_idx;
   logic             w_is_reg;
   logic             w_is_status;
   logic             commit_en;

   // ------------------------------------------------------------------
   // Read channel state
   // ------------------------------------------------------------------
   r_state_t    r_state_reg;
   logic        arready_reg;
   logic        rvalid_reg;
   logic [31:0] rdata_reg;
   logic [1:0]  rresp_reg;

   logic             ar_fire;
   logic [IDX_W-1:0] r_idx;
   logic             r_is_reg;
   logic             r_is_status;

   // Write side decodes the held address; read side decodes the live
   // araddr so rdata can be registered on the AR handshake edge.
   axi_lite_addr_decode #(
      .BASE_ADDR (BASE_ADDR),
      .N_REGS    (N_REGS),
      .IDX_W     (IDX_W)
   ) u_w_decode (
      .addr      (awaddr_reg),
      .idx       (w_idx),
      .is_reg    (w_is_reg),
      .is_status (w_is_status)
   );

   axi_lite_addr_decode #(
      .BASE_ADDR (BASE_ADDR),
      .N_REGS    (N_REGS),
      .IDX_W     (IDX_W)
   ) u_r_decode (
      .addr      (bus.araddr),
      .idx       (r_idx),
      .is_reg    (r_is_reg),
      .is_status (r_is_status)
   );

   assign aw_fire   = bus.awvalid && awready_reg;
   assign w_fire    = bus.wvalid && wready_reg;
   assign ar_fire   = bus.arvalid && arready_reg;
   assign commit_en = (w_state_reg == W_COMMIT) && w_is_reg;

   // ------------------------------------------------------------------
   // Write FSM. Readies are registered and only re-opened after the
   // B handshake, so a second AW/W cannot sneak in during W_RESP.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_reg  <= W_IDLE;
         aw_held_reg  <= 1'b0;
         w_held_reg   <= 1'b0;
         awaddr_reg   <= '0;
         wdata_reg    <= '0;
         wstrb_reg    <= '0;
         awready_reg  <= 1'b1;
         wready_reg   <= 1'b1;
         bvalid_reg   <= 1'b0;
         bresp_reg    <= RESP_OKAY;
         wr_pulse_reg <= '0;
      end else begin
         wr_pulse_reg <= '0;
         case (w_state_reg)
            W_IDLE: begin
               if (aw_fire) begin
                  awaddr_reg  <= bus.awaddr;
                  aw_held_reg <= 1'b1;
                  awready_reg <= 1'b0;
               end
               if (w_fire) begin
                  wdata_reg  <= bus.wdata;
                  wstrb_reg  <= bus.wstrb;
                  w_held_reg <= 1'b1;
                  wready_reg <= 1'b0;
               end
               if ((aw_held_reg || aw_fire) && (w_held_reg || w_fire)) begin
                  w_state_reg <= W_COMMIT;
               end
            end
            W_COMMIT: begin
               if (w_is_reg) begin
                  wr_pulse_reg[w_idx] <= 1'b1;
                  bresp_reg           <= RESP_OKAY;
               end else begin
                  // Status word and unmapped addresses are both rejected.
                  bresp_reg <= RESP_SLVERR;
               end
               bvalid_reg  <= 1'b1;
               w_state_reg <= W_RESP;
            end
            W_RESP: begin
               if (bus.bready) begin
                  bvalid_reg  <= 1'b0;
                  aw_held_reg <= 1'b0;
                  w_held_reg  <= 1'b0;
                  awready_reg <= 1'b1;
                  wready_reg  <= 1'b1;
                  w_state_reg <= W_IDLE;
               end
            end
            default: begin
               w_state_reg <= W_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Register file update: strobed byte merge during the commit cycle.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_REGS; i++) begin
            regs_reg[i] <= RESET_VAL;
         end
      end else if (commit_en) begin
         regs_reg[w_idx] <= merge_bytes(regs_reg[w_idx], wdata_reg, wstrb_reg);
      end
   end

   // ------------------------------------------------------------------
   // Read FSM. rdata is sampled from regs_reg on the AR edge, so a write
   // committing on that same edge is not visible to this read.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_reg <= R_IDLE;
         arready_reg <= 1'b1;
         rvalid_reg  <= 1'b0;
         rdata_reg   <= '0;
         rresp_reg   <= RESP_OKAY;
      end else begin
         case (r_state_reg)
            R_IDLE: begin
               if (ar_fire) begin
                  arready_reg <= 1'b0;
                  rvalid_reg  <= 1'b1;
                  r_state_reg <= R_DATA;
                  if (r_is_reg) begin
                     rdata_reg <= regs_reg[r_idx];
                     rresp_reg <= RESP_OKAY;
                  end else if (r_is_status) begin
                     rdata_reg <= status_in;
                     rresp_reg <= RESP_OKAY;
                  end else begin
                     rdata_reg <= '0;
                     rresp_reg <= RESP_SLVERR;
                  end
               end
            end
            R_DATA: begin
               if (bus.rready) begin
                  rvalid_reg  <= 1'b0;
                  arready_reg <= 1'b1;
                  r_state_reg <= R_IDLE;
               end
            end
            default: begin
               r_state_reg <= R_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.awready = awready_reg;
   assign bus.wready  = wready_reg;
   assign bus.bvalid  = bvalid_reg;
   assign bus.bresp   = bresp_reg;
   assign bus.arready = arready_reg;
   assign bus.rvalid  = rvalid_reg;
   assign bus.rdata   = rdata_reg;
   assign bus.rresp   = rresp_reg;
   assign wr_pulse    = wr_pulse_reg;

   for (genvar gi = 0; gi < N_REGS; gi++) begin : g_reg_out
      assign reg_out[gi*32 +: 32] = regs_reg[gi];
   end

endmodule

// File: doc/axi_lite_regs_slave.md
Name: axi_lite_regs_slave

Overview:
AXI-Lite responder (slave) register block, the far end of the core's AXI-Lite master port. It exposes N_REGS read/write 32-bit control registers and one read-only status word. It sits behind the SoC interconnect as a generic peripheral shell for timers, LEDs and scratch registers. It handles one outstanding write and one outstanding read, with independent read and write channels.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of register 0; must be aligned to the block size.
N_REGS, 8, number of RW registers (1..16); the status word sits at offset N_REGS*4.
RESET_VAL, 32'h0000_0000, reset value of every RW register.

Ports:
clk  in  1  single clock
rst  in  1  synchronous reset, active-high
s_axi_lite_awaddr  in  32  write address
s_axi_lite_awvalid  in  1  write address valid
s_axi_lite_awready  out  1  write address ready
s_axi_lite_wdata  in  32  write data
s_axi_lite_wstrb  in  4  byte enables
s_axi_lite_wvalid  in  1  write data valid
s_axi_lite_wready  out  1  write data ready
s_axi_lite_bresp  out  2  write response
s_axi_lite_bvalid  out  1  write response valid
s_axi_lite_bready  in  1  write response ready
s_axi_lite_araddr  in  32  read address
s_axi_lite_arvalid  in  1  read address valid
s_axi_lite_arready  out  1  read address ready
s_axi_lite_rdata  out  32  read data
s_axi_lite_rresp  out  2  read response
s_axi_lite_rvalid  out  1  read data valid
s_axi_lite_rready  in  1  read data ready
status_in  in  32  sampled into rdata when the status word is read
reg_out  out  N_REGS*32  flattened RW register contents; reg k occupies [32k+31:32k]
wr_pulse  out  N_REGS  one-cycle strobe on the cycle register k is written

Behaviour:
- Clock and reset: clk only; rst is synchronous and active-high.
- Reset: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, wr_pulse=0, all regs=RESET_VAL. Reset mid-transaction abandons it; no write is committed.
- Decode: off = addr - BASE_ADDR; addr[1:0] ignored; idx = off[31:2].
  - idx < N_REGS: RW register.
  - idx == N_REGS: status word (read-only).
  - Otherwise: out of range.
- Write FSM states:
  - W_IDLE: awready=!aw_held, wready=!w_held. AW and W are captured independently, in either order or in the same cycle. When both are held (capture cycle or later), go to W_COMMIT.
  - W_COMMIT (1 cycle): apply the write and go to W_RESP.
    - RW target: bytes with wstrb set are updated, the rest unchanged; wr_pulse[idx]=1; bresp=OKAY(00). wstrb=0 still returns OKAY and still pulses wr_pulse.
    - Status word: no change; bresp=SLVERR(10).
    - Out of range: no change; bresp=SLVERR(10).
  - W_RESP: bvalid=1, awready=wready=0. Stay until bready; on bvalid&&bready clear the held flags and go to W_IDLE.
  - Minimum AW/W-capture-to-bvalid latency: 2 cycles.
- Read FSM states:
  - R_IDLE: arready=1. On arvalid, capture the address and go to R_DATA.
  - R_DATA: rvalid=1, arready=0; rdata and rresp are registered on the capture edge and held stable until rready.
    - RW register: rdata=value, rresp=OKAY.
    - Status word: rdata=status_in sampled at capture, rresp=OKAY.
    - Out of range: rdata=0, rresp=SLVERR.
  - rvalid rises the cycle after the AR handshake. On rvalid&&rready go to R_IDLE; a new AR can be accepted the following cycle.
- Simultaneous events:
  - Read and write in flight to the same register: the read returns the value in the register at AR capture. A write committing in the same cycle is not seen.
  - The read and write channels never stall each other.
- AWVALID held while in W_RESP: not accepted; awready=0.

Decomposition:
- Shared package axi_lite_pkg holds:
  - response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - typedefs for the write FSM states (W_IDLE/W_COMMIT/W_RESP) and read FSM states (R_IDLE/R_DATA).
- One natural sub-module, axi_lite_addr_decode: combinational off/idx/in_range/is_status computation, instantiated once per channel.

Test Plan:
- AW and W in the same cycle: addr BASE+0x4, data 32'hDEADBEEF, wstrb 4'hF, bready=1 -> bvalid 2 cycles later with bresp 00; reg_out[63:32]=DEADBEEF; wr_pulse[1] high for exactly 1 cycle.
- W 3 cycles before AW: data 32'h11223344, wstrb 4'b0101 to reg0 holding 32'hAAAAAAAA -> reg0=AA22AA44; wready low after W capture until bresp handshake.
- Read status: status_in=32'hCAFE0001, araddr BASE+N_REGS*4, rready low for 4 cycles -> rvalid held, rdata=CAFE0001, rresp 00 stable throughout.
- Out of range: write addr BASE+0x100 -> bresp 10, no reg change; read addr BASE+0x100 -> rdata 0, rresp 10.
- Write reg2 with 32'h5 while read of reg2 (old value 32'h9) is captured in the commit cycle -> rdata=9, reg2=5 afterwards; bvalid held with bready=0 for 5 cycles -> no second AW accepted.
- Assert rst in W_RESP and in R_DATA -> next cycle bvalid=0, rvalid=0, all readies 1, regs=RESET_VAL.
